// File: rtl/cla_wide_add_seq_pkg.sv
// cla_wide_add_seq_pkg
//   Shared definitions for the wide add/subtract sequencer:
//   - state_t    : FSM state encodings (IDLE / RUN / DONE)
//   - CHUNK_W    : width of the single shared adder slice (16)
//   - CLA_WIDE_ADD_SEQ_WIDTH_OK(w) : legality test for the WIDTH parameter
//   - cla4_*     : 4-bit carry-lookahead helper equations used by the slice
//   No ports (package).

`ifndef CLA_WIDE_ADD_SEQ_WIDTH_OK
`define CLA_WIDE_ADD_SEQ_WIDTH_OK(w) ((((w) % 16) == 0) && ((w) >= 16))
`endif

package cla_wide_add_seq_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Carries out of bits 0..3 of a 4-bit group, fully expanded lookahead.
  function automatic logic [3:0] cla4_carries(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       c0);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Carries into bits 1..3 of a group (the group carry-out comes from the upper level).
  function automatic logic [2:0] cla4_inner(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate: the group produces a carry regardless of its carry-in.
  function automatic logic cla4_gen(input logic [3:0] g,
                                    input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/sumator_16bit.sv
// sumator_16bit
//   Purely combinational 16-bit two-level carry-lookahead adder
//   (four 4-bit groups, group carries resolved by a second lookahead level).
// Ports:
//   a, b  in  16  addends
//   cin   in  1   carry into bit 0
//   sum   out 16  a + b + cin (low 16 bits)
//   cout  out 1   carry out of bit 15

module sumator_16bit
  import cla_wide_add_seq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g_s;
  logic [15:0] p_s;
  logic [15:0] c_s;        // carry into each bit position
  logic [3:0]  grp_g_s;
  logic [3:0]  grp_p_s;
  logic [3:0]  grp_c_s;    // carry out of each 4-bit group
  logic [3:0]  grp_cin_s;  // carry into each 4-bit group

  assign g_s = a & b;
  assign p_s = a ^ b;

  for (genvar k = 0; k < 4; k++) begin : g_grp_gp
    assign grp_g_s[k] = cla4_gen(g_s[4*k +: 4], p_s[4*k +: 4]);
    assign grp_p_s[k] = &p_s[4*k +: 4];
  end

  // Second lookahead level over the group generate/propagate terms.
  assign grp_c_s   = cla4_carries(grp_g_s, grp_p_s, cin);
  assign grp_cin_s = {grp_c_s[2:0], cin};

  for (genvar k = 0; k < 4; k++) begin : g_grp_carry
    assign c_s[4*k +: 4] = {cla4_inner(g_s[4*k +: 4], p_s[4*k +: 4], grp_cin_s[k]),
                            grp_cin_s[k]};
  end

  assign sum  = p_s ^ c_s;
  assign cout = grp_c_s[3];

endmodule

// File: rtl/cla_wide_add_seq.sv
// cla_wide_add_seq
//   Multi-cycle WIDTH-bit add/subtract built around a single shared 16-bit
//   CLA slice. Operands are taken over a valid/ready handshake, processed one
//   16-bit chunk per clock (LSB first) with the carry chained through a
//   register, and the result is offered over a second valid/ready handshake.
// Ports:
//   clk, rst    in          clock (rising edge), async active-high reset
//   in_valid    in   1      operation request
//   in_ready    out  1      high only in IDLE
//   op_a, op_b  in   WIDTH  operands, sampled on the input handshake
//   op_cin      in   1      carry-in for add (ignored for subtract)
//   op_sub      in   1      1: result = A - B
//   out_valid   out  1      result available (DONE)
//   out_ready   in   1      consumer accepts result
//   result      out  WIDTH  sum / difference
//   cout        out  1      carry out of bit WIDTH-1 (subtract: 1 = no borrow)
//   ovf         out  1      signed overflow
//   busy        out  1      high in RUN or DONE

module cla_wide_add_seq
  import cla_wide_add_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (!(`CLA_WIDE_ADD_SEQ_WIDTH_OK(WIDTH))) begin : g_width_illegal
    $error("cla_wide_add_seq: WIDTH must be a multiple of 16 and >= 16");
  end

  state_t             state_r;
  state_t             state_s;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;      // B already inverted for subtract
  logic [WIDTH-1:0]   result_r;
  logic               cout_r;
  logic               ovf_r;

  logic               accept_s;
  logic               last_s;
  logic [CHUNK_W-1:0] chunk_a_s;
  logic [CHUNK_W-1:0] chunk_b_s;
  logic [CHUNK_W-1:0] sum_s;
  logic               adder_cout_s;

  assign accept_s  = in_valid && (state_r == ST_IDLE);
  assign last_s    = (idx_r == IDX_W'(NCHUNK - 1));
  assign chunk_a_s = a_r[CHUNK_W*int'(idx_r) +: CHUNK_W];
  assign chunk_b_s = b_r[CHUNK_W*int'(idx_r) +: CHUNK_W];

  sumator_16bit u_slice (
    .a    (chunk_a_s),
    .b    (chunk_b_s),
    .cin  (carry_r),
    .sum  (sum_s),
    .cout (adder_cout_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs, decoded from the registered state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
      end
    endcase
  end

  // Operand capture, per-chunk accumulation and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IDX_W{1'b0}};
      carry_r  <= 1'b0;
      a_r      <= {WIDTH{1'b0}};
      b_r      <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r     <= op_a;
            b_r     <= op_sub ? ~op_b : op_b;
            carry_r <= op_sub ? 1'b1 : op_cin;
            idx_r   <= {IDX_W{1'b0}};
          end
        end
        ST_RUN: begin
          result_r[CHUNK_W*int'(idx_r) +: CHUNK_W] <= sum_s;
          carry_r <= adder_cout_s;
          if (last_s) begin
            cout_r <= adder_cout_s;
            // Overflow: same-sign operands producing a result of the other sign.
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_s[CHUNK_W-1] != a_r[WIDTH-1]);
            idx_r  <= {IDX_W{1'b0}};
          end else begin
            idx_r  <= idx_r + IDX_W'(1);
          end
        end
        ST_DONE: begin
          idx_r <= idx_r;
        end
        default: begin
          idx_r <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign result = result_r;
  assign cout   = cout_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_cla_wide_add_seq.sv
module tb_cla_wide_add_seq;

  localparam int W   = 64;
  localparam int NCH = W / 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic         op_sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_wide_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the operation's definition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       input logic sub, output logic [W-1:0] r, output logic co,
                       output logic ov);
    logic [W-1:0] beff;
    logic [W:0]   full;
    beff = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    r    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == beff[W-1]) && (r[W-1] != a[W-1]);
  endtask

  task automatic wait_ready(input string tag);
    int wt;
    wt = 0;
    while (!in_ready && wt < 20) begin
      @(posedge clk); #1;
      wt++;
    end
    check({tag, " ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input int hold);
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    int           lat;
    model(a, b, cin, sub, er, ec, eo);
    wait_ready(tag);
    in_valid = 1'b1; op_a = a; op_b = b; op_cin = cin; op_sub = sub;
    @(posedge clk); #1;
    // Operand changes after acceptance must be ignored.
    in_valid = 1'b0;
    op_a = {$urandom(), $urandom()}; op_b = {$urandom(), $urandom()};
    op_cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
    out_ready = (hold == 0);
    lat = 0;
    while (!out_valid && lat < 3*NCH + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(NCH));
    check({tag, " result"}, result, er);
    check({tag, " cout"}, {63'd0, cout}, {63'd0, ec});
    check({tag, " ovf"}, {63'd0, ovf}, {63'd0, eo});
    check({tag, " done in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, " done busy"}, {63'd0, busy}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold valid"}, {63'd0, out_valid}, 64'd1);
      check({tag, " hold result"}, result, er);
      check({tag, " hold flags"}, {62'd0, cout, ovf}, {62'd0, ec, eo});
      check({tag, " hold in_ready"}, {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " idle valid"}, {63'd0, out_valid}, 64'd0);
    check({tag, " idle ready"}, {62'd0, in_ready, busy}, 64'd2);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           lat;

    rst = 1'b1; in_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset in_ready", {63'd0, in_ready}, 64'd1);
    check("reset out_valid", {63'd0, out_valid}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset result", result, 64'd0);
    check("reset flags", {62'd0, cout, ovf}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op("add_small", 64'd1, 64'd2, 1'b0, 1'b0, 0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 0);
    run_op("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 0);
    run_op("sub", 64'd5, 64'd7, 1'b0, 1'b1, 0);
    run_op("sub_eq", 64'h1234, 64'h1234, 1'b0, 1'b1, 0);
    run_op("sub_cin_ignored", 64'd100, 64'd1, 1'b1, 1'b1, 0);
    run_op("neg_ovf", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0);
    run_op("backpressure", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 10);

    // in_valid held through DONE: no accept on the DONE->IDLE edge.
    wait_ready("b2b");
    in_valid = 1'b1; op_a = 64'd10; op_b = 64'd20; op_cin = 1'b0; op_sub = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    lat = 0;
    while (!out_valid && lat < 3*NCH + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b first result", result, 64'd30);
    check("b2b done in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    check("b2b not accepted on exit", {62'd0, in_ready, busy}, 64'd2);
    @(posedge clk); #1;
    check("b2b accepted next", {62'd0, in_ready, busy}, 64'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3*NCH + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b second result", result, 64'd30);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the middle of an operation.
    wait_ready("rst_mid");
    in_valid = 1'b1; op_a = 64'hDEAD_BEEF_0000_0001; op_b = 64'h1111; op_cin = 1'b0; op_sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_mid in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mid out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid busy", {63'd0, busy}, 64'd0);
    check("rst_mid result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 0);

    // Randomized operations against the arithmetic reference.
    for (int i = 0; i < 24; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      if (i % 6 == 1) ra[W-1:16] = '1;
      if (i % 6 == 2) rb = ra;
      run_op("random", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
